// File: rtl/flag_pkg.sv
// Shared definitions for the flag register: flag bit positions, ALU opcode
// encoding and the opcode-to-update-mask decode.
package flag_pkg;

  localparam int FLAG_BITS = 7;

  localparam int FLAG_OVF = 6;
  localparam int FLAG_ABV = 5;
  localparam int FLAG_EQ  = 4;
  localparam int FLAG_BLW = 3;
  localparam int FLAG_BTW = 2;
  localparam int FLAG_COL = 1;
  localparam int FLAG_ERR = 0;

  typedef enum logic [3:0] {
    OP_INV = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_MUL = 4'h3,
    OP_DIV = 4'h4,
    OP_MOV = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_SHL = 4'h9,
    OP_SHR = 4'hA,
    OP_CMP = 4'hB,
    OP_NOT = 4'hC,
    OP_JMP = 4'hD,
    OP_BR  = 4'hE,
    OP_NOP = 4'hF
  } alu_op_e;

  // Which stored flag bits an opcode is allowed to overwrite on commit.
  // Bits [2:1] are never covered; they belong to the external range unit.
  function automatic logic [FLAG_BITS-1:0] update_mask(input logic [3:0] op);
    logic [FLAG_BITS-1:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
        m[FLAG_OVF] = 1'b1;
        m[FLAG_ERR] = 1'b1;
      end
      OP_CMP: begin
        m[FLAG_ABV] = 1'b1;
        m[FLAG_EQ]  = 1'b1;
        m[FLAG_BLW] = 1'b1;
      end
      OP_INV: m[FLAG_ERR] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// Small LIFO for saving/restoring the flag vector across calls/interrupts.
// The top entry is presented combinationally so a pop restores in one cycle.
module flag_stack #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         pop_ok,
  output logic         full,
  output logic         empty,
  output logic         err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          push_ok;
  logic [AW-1:0] top_idx;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Simultaneous push and pop is treated as illegal, so both are dropped.
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;

  // DEPTH is a power of two, so the low count bits wrap to the right slot
  // even when the stack is full.
  assign top_idx = cnt_q[AW-1:0] - AW'(1);
  assign dout    = mem_q[top_idx];

  // Next count and illegal-operation detection.
  always_comb begin
    cnt_d = cnt_q;
    if (push_ok)     cnt_d = cnt_q + CW'(1);
    else if (pop_ok) cnt_d = cnt_q - CW'(1);
    err_d = (push & pop) | (push & full) | (pop & empty);
  end

  // Count and error pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Storage needs no reset; a push coinciding with reset is abandoned.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[cnt_q[AW-1:0]] <= din;
  end

  assign err = err_q;

endmodule

// File: rtl/flag_register.sv
// Stored ALU flags with per-opcode update masks, external [2:1] writes,
// save/restore stack and a sticky error request to the control unit.
module flag_register
  import flag_pkg::*;
#(
  parameter int FLAG_W = FLAG_BITS,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        alu_op,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              alu_we,
  input  logic              ext_we,
  input  logic [1:0]        ext_flags,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic              err_ack,
  output logic [FLAG_W-1:0] flags_stored,
  output logic [FLAG_W-1:0] flags_fwd,
  output logic              err_req,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [FLAG_W-1:0] upd;
  logic [FLAG_W-1:0] mask;
  logic [FLAG_W-1:0] stk_dout;
  logic              stk_pop_ok;
  logic              err_q, err_d;
  logic              err_ev;

  assign mask = update_mask(alu_op);

  flag_stack #(
    .W     (FLAG_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .din    (flags_q),
    .dout   (stk_dout),
    .pop_ok (stk_pop_ok),
    .full   (stack_full),
    .empty  (stack_empty),
    .err    (stack_err)
  );

  // Next flag value: restore beats clear beats the merged ALU/external update.
  always_comb begin
    upd = flags_q;
    if (alu_we) upd = (flags_q & ~mask) | (alu_flags & mask);
    if (ext_we) upd[FLAG_BTW:FLAG_COL] = ext_flags;

    if (stk_pop_ok) flags_d = stk_dout;
    else if (clr)   flags_d = '0;
    else            flags_d = upd;

    err_ev = alu_we & mask[FLAG_ERR] & alu_flags[FLAG_ERR];
    err_d  = err_q;
    if (err_ev)       err_d = 1'b1;
    else if (err_ack) err_d = 1'b0;
  end

  // Flag and error-request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign flags_stored = flags_q;
  assign flags_fwd    = reset ? '0 : flags_d;
  assign err_req      = err_q;

endmodule

// File: doc/flag_register.md
Name: flag_register

Overview:
- Sequential flag store that sits on the far side of the ALU flag interface.
- Captures the 7-bit flag vector the ALU produces, applies per-opcode update masks, and drives the stored-flag vector back into the ALU for conditional-branch evaluation.
- Also provides a small save/restore stack for interrupt/call context, and a sticky error-request handshake to the control unit.

Parameters:
- FLAG_W, 7, flag vector width: [6] overflow, [5] above, [4] equal, [3] below, [2] between, [1] collision, [0] error.
- DEPTH, 4, save/restore stack entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- alu_op  in  4  opcode of the instruction committing this cycle (ALU encoding).
- alu_flags  in  FLAG_W  flag vector generated by the ALU for alu_op.
- alu_we  in  1  commit strobe; flags are updated only when high.
- ext_we  in  1  write strobe from the collision/range unit.
- ext_flags  in  2  new values for bits [2:1] (between, collision).
- clr  in  1  clears all stored flags.
- push  in  1  save current flags onto the stack.
- pop  in  1  restore flags from the stack.
- err_ack  in  1  control unit acknowledges the error request.
- flags_stored  out  FLAG_W  registered flag vector, fed to the ALU stored-flag input.
- flags_fwd  out  FLAG_W  combinational value flags_stored will take next cycle (forwarding path).
- err_req  out  1  sticky error request.
- stack_full  out  1  stack holds DEPTH entries.
- stack_empty  out  1  stack holds 0 entries.
- stack_err  out  1  one-cycle pulse on an illegal stack operation.

Behaviour:
- One clock, clk. Synchronous, active-high reset on reset.
- Reset values:
  - flags_stored = 0, err_req = 0, stack_err = 0.
  - Stack count = 0, so stack_empty = 1 and stack_full = 0.
  - Stack contents are don't-care.
- Update masks apply when alu_we = 1. Only the masked bits are written; all others hold.
  - 0001–0100 (add/sub/mul/div): bits [6] and [0].
  - 1011 (compare): bits [5:3].
  - 0000 (invalid): bit [0].
  - All other opcodes (move, logic, shift, not, jump, branch, nop): no flag change.
- ext_we = 1 writes bits [2:1] from ext_flags.
  - ALU masks never cover [2:1], so ext_we and alu_we in the same cycle both take effect.
- Priority per cycle (highest first): reset > pop > clr > (alu_we, ext_we merged).
  - A pop in the same cycle as clr or alu_we: the restored value wins; clr and the update are discarded.
- push:
  - Stores the pre-update flags_stored value (this cycle's register contents).
  - Same-cycle alu_we, ext_we and clr still apply to flags_stored.
- Latency:
  - flags_stored changes one cycle after the strobe.
  - flags_fwd equals the next-state value in the same cycle, with no extra latency.
- Stack:
  - LIFO with a count of 0..DEPTH.
  - push while full: ignored, stack_err = 1 for one cycle.
  - pop while empty: ignored, stack_err = 1 for one cycle, flags untouched (clr and update then apply normally).
  - push and pop in the same cycle: both ignored, stack_err = 1; clr and update apply normally.
  - stack_full and stack_empty are registered-count decodes.
- Error request:
  - An error event is alu_we = 1, the op's mask covers bit 0, and alu_flags[0] = 1.
  - An error event sets err_req the next cycle.
  - err_ack = 1 clears err_req the next cycle.
  - An error event and err_ack in the same cycle leave err_req = 1 (new error wins).
  - clr and pop do not affect err_req.
- Reset asserted mid-operation abandons any pending push, pop or error and returns all state to reset values the next cycle.

Decomposition:
- Shared package (flag_pkg) holds:
  - Flag bit-index constants FLAG_OVF=6, FLAG_ABV=5, FLAG_EQ=4, FLAG_BLW=3, FLAG_BTW=2, FLAG_COL=1, FLAG_ERR=0.
  - ALU opcode constants (OP_ADD..OP_NOP).
  - The function opcode→update mask, shared with the decoder.
- One sub-module: flag_stack (parameterised LIFO: push, pop, data in/out, full/empty, err).

Test Plan:
- Reset, then alu_we with op=0001 and alu_flags=7'b1111111 → next cycle flags_stored=7'b1000001, err_req=1.
- From flags=0, op=1011 with alu_flags=7'b0010000, plus ext_we with ext_flags=2'b11 in the same cycle → flags_stored=7'b0010110, and flags_fwd shows it in the strobe cycle.
- Set flags=7'b0001000, then push together with alu_we op=1011 alu_flags=7'b0100000 → flags_stored=7'b0100000; then pop → flags_stored=7'b0001000.
- Push 4 times (DEPTH=4) → stack_full=1; a 5th push → stack_err pulses one cycle, count stays 4. Pop 5 times → the 5th pops stack_err, stack_empty=1.
- Hold err_req=1, then assert err_ack together with a new error event (op=0100, alu_flags[0]=1) → err_req stays 1; err_ack alone the next cycle → err_req=0.
- Assert reset during simultaneous push and alu_we → next cycle all outputs at reset values, stack_empty=1.
